// File: rtl/gpu_pkg.sv
// Shared frame-buffer geometry, colours, pixel request payload and arbiter state encoding.
package gpu_pkg;

  localparam int unsigned H_RES  = 640;
  localparam int unsigned V_RES  = 400;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROW_W  = 10;
  localparam int unsigned COL_W  = 10;

  localparam logic [DATA_W-1:0] WHITE = 16'hFFFF;
  localparam logic [DATA_W-1:0] BG    = 16'h0430;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } pix_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/gpu_rr_arb2.sv
// Two-way round-robin grant; the last-served pointer moves only when a transfer completes.
module gpu_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_xfer,
  output logic       o_grant
);

  logic r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_xfer) begin
      r_last <= o_grant;
    end
  end

  // A lone requester wins outright; contention (or no request) favours the one not served last.
  always_comb begin
    if (i_valid == 2'b01) begin
      o_grant = 1'b0;
    end else if (i_valid == 2'b10) begin
      o_grant = 1'b1;
    end else begin
      o_grant = ~r_last;
    end
  end

endmodule

// File: rtl/gpu_fb_arbiter.sv
// Arbitrates two pixel producers onto the SRAM write port, linearising (row, col) and
// holding the single pending write until the display enters blanking.
module gpu_fb_arbiter
  import gpu_pkg::*;
(
  input  logic              I_CLK,
  input  logic              I_RST,
  input  logic              I_VIDEO_ON,
  input  logic [1:0]        I_REQ_VALID,
  input  logic [19:0]       I_REQ_ROW,
  input  logic [19:0]       I_REQ_COL,
  input  logic [31:0]       I_REQ_DATA,
  output logic [1:0]        O_REQ_READY,
  output logic [ADDR_W-1:0] O_GPU_ADDR,
  output logic [DATA_W-1:0] O_GPU_DATA,
  output logic              O_GPU_WRITE,
  output logic              O_GPU_READ,
  output logic [15:0]       O_WR_CNT,
  output logic [7:0]        O_DROP_CNT
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic [15:0]       r_wr_cnt;
  logic [7:0]        r_drop_cnt;

  logic              w_grant;
  logic              w_pend_valid;
  logic              w_hold;
  logic [1:0]        w_ready;
  logic              w_xfer;
  logic              w_in_range;
  logic              w_fill;
  logic              w_write;
  pix_req_t          w_sel;
  logic [ADDR_W-1:0] w_addr;

  gpu_rr_arb2 u_rr (
    .i_clk   (I_CLK),
    .i_rst   (I_RST),
    .i_valid (I_REQ_VALID),
    .i_xfer  (w_xfer),
    .o_grant (w_grant)
  );

  assign w_pend_valid = (r_state != IDLE);
  assign w_hold       = w_pend_valid && I_VIDEO_ON;
  assign w_ready      = (!I_RST && !I_VIDEO_ON && !w_hold) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_xfer       = |(I_REQ_VALID & w_ready);

  assign w_sel.row  = w_grant ? I_REQ_ROW[19:10]  : I_REQ_ROW[9:0];
  assign w_sel.col  = w_grant ? I_REQ_COL[19:10]  : I_REQ_COL[9:0];
  assign w_sel.data = w_grant ? I_REQ_DATA[31:16] : I_REQ_DATA[15:0];

  // Off-screen pixels are still handshaken so a producer never stalls on them.
  assign w_in_range = (w_sel.row < ROW_W'(V_RES)) && (w_sel.col < COL_W'(H_RES));
  assign w_addr     = ADDR_W'(w_sel.row) * ADDR_W'(H_RES) + ADDR_W'(w_sel.col);
  assign w_fill     = w_xfer && w_in_range;
  assign w_write    = w_pend_valid && !I_VIDEO_ON && !I_RST;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The entry drains whenever the display is blanked; a new fill may replace it on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_fill) w_state_nxt = PEND;
      end
      PEND, HOLD: begin
        if (I_VIDEO_ON)  w_state_nxt = HOLD;
        else if (w_fill) w_state_nxt = PEND;
        else             w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_wr_cnt    <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_fill) begin
        r_pend_addr <= w_addr;
        r_pend_data <= w_sel.data;
      end
      if (w_write) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_xfer && !w_in_range && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign O_REQ_READY = w_ready;
  assign O_GPU_ADDR  = r_pend_addr;
  assign O_GPU_DATA  = r_pend_data;
  assign O_GPU_WRITE = w_write;
  assign O_GPU_READ  = 1'b0;
  assign O_WR_CNT    = r_wr_cnt;
  assign O_DROP_CNT  = r_drop_cnt;

endmodule

// File: tb/tb_gpu_fb_arbiter.sv
// Directed per-cycle vector table plus hand-written saturation and reset-in-HOLD sequences.
module tb_gpu_fb_arbiter;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid;
  logic [1:0]  valid;
  logic [19:0] row;
  logic [19:0] col;
  logic [31:0] data;
  logic [1:0]  ready;
  logic [17:0] addr;
  logic [15:0] wdata;
  logic        wr;
  logic        rd;
  logic [15:0] wr_cnt;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpu_fb_arbiter dut (
    .I_CLK       (clk),
    .I_RST       (rst),
    .I_VIDEO_ON  (vid),
    .I_REQ_VALID (valid),
    .I_REQ_ROW   (row),
    .I_REQ_COL   (col),
    .I_REQ_DATA  (data),
    .O_REQ_READY (ready),
    .O_GPU_ADDR  (addr),
    .O_GPU_DATA  (wdata),
    .O_GPU_WRITE (wr),
    .O_GPU_READ  (rd),
    .O_WR_CNT    (wr_cnt),
    .O_DROP_CNT  (drop_cnt)
  );

  typedef struct {
    logic        rst;
    logic        vid;
    logic [1:0]  valid;
    logic [9:0]  r0;
    logic [9:0]  c0;
    logic [15:0] d0;
    logic [9:0]  r1;
    logic [9:0]  c1;
    logic [15:0] d1;
    logic [1:0]  e_ready;
    logic        e_write;
    logic [17:0] e_addr;
    logic [15:0] e_data;
    logic [15:0] e_wr;
    logic [7:0]  e_drop;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  function automatic vec_t mk(logic r, logic v, logic [1:0] va,
                              logic [9:0] r0, logic [9:0] c0, logic [15:0] d0,
                              logic [9:0] r1, logic [9:0] c1, logic [15:0] d1,
                              logic [1:0] er, logic ew, logic [17:0] ea, logic [15:0] ed,
                              logic [15:0] ewc, logic [7:0] edc);
    vec_t t;
    t.rst = r; t.vid = v; t.valid = va;
    t.r0 = r0; t.c0 = c0; t.d0 = d0; t.r1 = r1; t.c1 = c1; t.d1 = d1;
    t.e_ready = er; t.e_write = ew; t.e_addr = ea; t.e_data = ed; t.e_wr = ewc; t.e_drop = edc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] va,
                       input logic [9:0] r0, input logic [9:0] c0, input logic [15:0] d0,
                       input logic [9:0] r1, input logic [9:0] c1, input logic [15:0] d1);
    rst = r; vid = v; valid = va;
    row = {r1, r0}; col = {c1, c0}; data = {d1, d0};
  endtask

  initial begin
    // reset, single pixel, contention
    vecs[0]  = mk(1, 0, 2'b11, 1, 2, WHITE, 3, 4, BG,      2'b00, 0, 0,      16'h0000, 0, 0);
    vecs[1]  = mk(0, 0, 2'b01, 1, 2, WHITE, 3, 4, BG,      2'b01, 0, 0,      16'h0000, 0, 0);
    vecs[2]  = mk(0, 0, 2'b00, 1, 2, WHITE, 3, 4, BG,      2'b10, 1, 642,    16'hFFFF, 0, 0);
    vecs[3]  = mk(0, 0, 2'b00, 1, 2, WHITE, 3, 4, BG,      2'b10, 0, 642,    16'hFFFF, 1, 0);
    vecs[4]  = mk(0, 0, 2'b11, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b10, 0, 642,  16'hFFFF, 1, 0);
    vecs[5]  = mk(0, 0, 2'b11, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b01, 1, 1285, 16'h2222, 1, 0);
    vecs[6]  = mk(0, 0, 2'b11, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b10, 1, 10,   16'h1111, 2, 0);
    vecs[7]  = mk(0, 0, 2'b11, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b01, 1, 1285, 16'h2222, 3, 0);
    vecs[8]  = mk(0, 0, 2'b11, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b10, 1, 10,   16'h1111, 4, 0);
    vecs[9]  = mk(0, 0, 2'b11, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b01, 1, 1285, 16'h2222, 5, 0);
    vecs[10] = mk(0, 0, 2'b00, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b10, 1, 10,   16'h1111, 6, 0);
    vecs[11] = mk(0, 0, 2'b00, 0, 10, 16'h1111, 2, 5, 16'h2222, 2'b10, 0, 10,   16'h1111, 7, 0);
    // blanking boundary: fill on the edge where video rises, five held cycles
    vecs[12] = mk(0, 0, 2'b01, 5, 7, 16'hABCD, 3, 4, BG,   2'b01, 0, 10,     16'h1111, 7, 0);
    vecs[13] = mk(0, 1, 2'b00, 1, 2, WHITE, 3, 4, BG,      2'b00, 0, 3207,   16'hABCD, 7, 0);
    vecs[14] = mk(0, 1, 2'b11, 1, 2, WHITE, 3, 4, BG,      2'b00, 0, 3207,   16'hABCD, 7, 0);
    vecs[15] = mk(0, 1, 2'b11, 1, 2, WHITE, 3, 4, BG,      2'b00, 0, 3207,   16'hABCD, 7, 0);
    vecs[16] = mk(0, 1, 2'b11, 1, 2, WHITE, 3, 4, BG,      2'b00, 0, 3207,   16'hABCD, 7, 0);
    vecs[17] = mk(0, 1, 2'b11, 1, 2, WHITE, 3, 4, BG,      2'b00, 0, 3207,   16'hABCD, 7, 0);
    vecs[18] = mk(0, 0, 2'b00, 1, 2, WHITE, 3, 4, BG,      2'b10, 1, 3207,   16'hABCD, 7, 0);
    vecs[19] = mk(0, 0, 2'b00, 1, 2, WHITE, 3, 4, BG,      2'b10, 0, 3207,   16'hABCD, 8, 0);
    // range corners
    vecs[20] = mk(0, 0, 2'b01, 399, 639, 16'h1234, 0, 0, 0,  2'b01, 0, 3207,   16'hABCD, 8, 0);
    vecs[21] = mk(0, 0, 2'b01, 400, 0, 16'h5555, 0, 0, 0,    2'b01, 1, 255999, 16'h1234, 8, 0);
    vecs[22] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0,             2'b10, 0, 255999, 16'h1234, 9, 1);
    vecs[23] = mk(0, 0, 2'b10, 0, 0, 0, 0, 640, 16'h7777,    2'b10, 0, 255999, 16'h1234, 9, 1);
    vecs[24] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0,             2'b01, 0, 255999, 16'h1234, 9, 2);

    drive(1, 0, 2'b11, 1, 2, WHITE, 3, 4, BG);
    @(posedge clk);
    for (int i = 0; i < NV; i++) begin
      #1;
      drive(vecs[i].rst, vecs[i].vid, vecs[i].valid, vecs[i].r0, vecs[i].c0, vecs[i].d0,
            vecs[i].r1, vecs[i].c1, vecs[i].d1);
      #4;
      check($sformatf("v%0d_ready", i), 32'(ready),    32'(vecs[i].e_ready));
      check($sformatf("v%0d_write", i), 32'(wr),       32'(vecs[i].e_write));
      check($sformatf("v%0d_addr", i),  32'(addr),     32'(vecs[i].e_addr));
      check($sformatf("v%0d_data", i),  32'(wdata),    32'(vecs[i].e_data));
      check($sformatf("v%0d_wrcnt", i), 32'(wr_cnt),   32'(vecs[i].e_wr));
      check($sformatf("v%0d_drop", i),  32'(drop_cnt), 32'(vecs[i].e_drop));
      check($sformatf("v%0d_read", i),  32'(rd),       32'(0));
      @(posedge clk);
    end

    // 300 off-screen pixels from both producers: drop counter saturates, nothing written
    for (int i = 0; i < 300; i++) begin
      #1;
      drive(0, 0, 2'b11, 400, 0, 16'h0001, 0, 640, 16'h0002);
      @(posedge clk);
    end
    #1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    #4;
    check("sat_drop",  32'(drop_cnt), 32'(255));
    check("sat_wrcnt", 32'(wr_cnt),   32'(9));
    check("sat_write", 32'(wr),       32'(0));

    // reset while an entry is held: it must be discarded
    @(posedge clk); #1;
    drive(0, 0, 2'b01, 1, 2, WHITE, 0, 0, 0);
    #4;
    check("rh_ready0", 32'(ready), 32'(2'b01));
    @(posedge clk); #1;
    drive(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    #4;
    check("rh_hold_write", 32'(wr),   32'(0));
    check("rh_hold_addr",  32'(addr), 32'(642));
    @(posedge clk); #1;
    drive(1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    #4;
    check("rh_rst_ready", 32'(ready), 32'(0));
    @(posedge clk); #1;
    drive(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    #4;
    check("rh_post_addr", 32'(addr), 32'(0));
    @(posedge clk); #1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    #4;
    check("rh_blank_write", 32'(wr),       32'(0));
    check("rh_blank_ready", 32'(ready),    32'(2'b01));
    check("rh_wrcnt",       32'(wr_cnt),   32'(0));
    check("rh_drop",        32'(drop_cnt), 32'(0));
    @(posedge clk); #5;
    check("rh_write_next",  32'(wr),       32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
